// File: rtl/stage30_out_queue.sv
// stage30_out_queue: per-class output FIFOs with a bounded-priority arbiter.
// Optional drop counters: define STAGE30_OUT_QUEUE_DROP_STATS_EN.
package types;
  typedef logic [7:0] flit_t;
endpackage

module stage30_out_queue
  import types::*;
#(
  parameter int FLIT_WIDTH = $bits(flit_t),
  parameter int SYS_DEPTH  = 4,
  parameter int NORM_DEPTH = 8,
  parameter int SYS_BURST  = 2
) (
  input  logic                  nocclk,
  input  logic                  rst,
  input  logic                  in_sys_flit_valid,
  input  logic [FLIT_WIDTH-1:0] in_sys_flit,
  output logic                  out_sys_ready,
  input  logic                  in_normal_flit_valid,
  input  logic [FLIT_WIDTH-1:0] in_normal_flit,
  output logic                  out_normal_ready,
  output logic                  out_flit_valid,
  output logic [FLIT_WIDTH-1:0] out_flit,
  input  logic                  in_flit_ready,
  input  logic                  in_flush,
`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
  output logic [15:0]           out_sys_drop_count,
  output logic [15:0]           out_normal_drop_count,
`endif
  output logic [$clog2(SYS_DEPTH+1)-1:0]  out_sys_count,
  output logic [$clog2(NORM_DEPTH+1)-1:0] out_normal_count
);

  localparam int SPW = $clog2(SYS_DEPTH);
  localparam int NPW = $clog2(NORM_DEPTH);
  localparam int SCW = $clog2(SYS_DEPTH+1);
  localparam int NCW = $clog2(NORM_DEPTH+1);
  localparam int BW  = $clog2(SYS_BURST+1);

  localparam logic [SCW-1:0] SYS_FULL  = SCW'(SYS_DEPTH);
  localparam logic [NCW-1:0] NORM_FULL = NCW'(NORM_DEPTH);
  localparam logic [BW-1:0]  BURST_MAX = BW'(SYS_BURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYS,
    ST_NORM
  } state_t;

  state_t state, state_n;

  logic [FLIT_WIDTH-1:0] sys_mem  [SYS_DEPTH];
  logic [FLIT_WIDTH-1:0] norm_mem [NORM_DEPTH];

  logic [SPW-1:0] sys_wr, sys_rd;
  logic [NPW-1:0] norm_wr, norm_rd;
  logic [SCW-1:0] sys_cnt, sys_cnt_n;
  logic [NCW-1:0] norm_cnt, norm_cnt_n;
  logic [BW-1:0]  burst, burst_n;

  logic sys_push, norm_push;
  logic pop, sys_pop, norm_pop;
  logic lock;

  assign out_sys_ready    = (sys_cnt != SYS_FULL);
  assign out_normal_ready = (norm_cnt != NORM_FULL);
  assign out_sys_count    = sys_cnt;
  assign out_normal_count = norm_cnt;
  assign out_flit_valid   = (state != ST_IDLE);

  // A stalled grant holds its state and data until accepted.
  assign lock = out_flit_valid & ~in_flit_ready;

  assign sys_push  = in_sys_flit_valid & out_sys_ready & ~in_flush;
  assign norm_push = in_normal_flit_valid & out_normal_ready & ~in_flush;
  assign pop       = out_flit_valid & in_flit_ready & ~in_flush;
  assign sys_pop   = pop & (state == ST_SYS);
  assign norm_pop  = pop & (state == ST_NORM);

  // Present the head of the granted class; zero when idle.
  always_comb begin
    out_flit = '0;
    if (state == ST_SYS)
      out_flit = sys_mem[sys_rd];
    else if (state == ST_NORM)
      out_flit = norm_mem[norm_rd];
  end

  // Occupancy after this edge's push/pop/flush.
  always_comb begin
    sys_cnt_n  = sys_cnt;
    norm_cnt_n = norm_cnt;
    if (in_flush) begin
      sys_cnt_n  = '0;
      norm_cnt_n = '0;
    end else begin
      if (sys_push && !sys_pop)
        sys_cnt_n = sys_cnt + 1'b1;
      else if (!sys_push && sys_pop)
        sys_cnt_n = sys_cnt - 1'b1;
      if (norm_push && !norm_pop)
        norm_cnt_n = norm_cnt + 1'b1;
      else if (!norm_push && norm_pop)
        norm_cnt_n = norm_cnt - 1'b1;
    end
  end

  // Count back-to-back system grants while normal traffic waits.
  always_comb begin
    burst_n = burst;
    if (in_flush || norm_pop || norm_cnt == '0)
      burst_n = '0;
    else if (sys_pop && burst < BURST_MAX)
      burst_n = burst + 1'b1;
  end

  // Arbitrate on next-cycle occupancy so a fresh flit shows one cycle later.
  always_comb begin
    state_n = state;
    if (in_flush)
      state_n = ST_IDLE;
    else if (!lock) begin
      if (sys_cnt_n != '0 &&
          (burst_n < BURST_MAX || norm_cnt_n == '0))
        state_n = ST_SYS;
      else if (norm_cnt_n != '0)
        state_n = ST_NORM;
      else
        state_n = ST_IDLE;
    end
  end

  // Grant state, occupancy and burst registers.
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sys_cnt  <= '0;
      norm_cnt <= '0;
      burst    <= '0;
    end else begin
      state    <= state_n;
      sys_cnt  <= sys_cnt_n;
      norm_cnt <= norm_cnt_n;
      burst    <= burst_n;
    end
  end

  // Read/write pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      sys_wr  <= '0;
      sys_rd  <= '0;
      norm_wr <= '0;
      norm_rd <= '0;
    end else if (in_flush) begin
      sys_wr  <= '0;
      sys_rd  <= '0;
      norm_wr <= '0;
      norm_rd <= '0;
    end else begin
      if (sys_push)  sys_wr  <= sys_wr + 1'b1;
      if (sys_pop)   sys_rd  <= sys_rd + 1'b1;
      if (norm_push) norm_wr <= norm_wr + 1'b1;
      if (norm_pop)  norm_rd <= norm_rd + 1'b1;
    end
  end

  // Storage arrays; contents are don't-care until written.
  always_ff @(posedge nocclk) begin
    if (sys_push)  sys_mem[sys_wr]   <= in_sys_flit;
    if (norm_push) norm_mem[norm_wr] <= in_normal_flit;
  end

`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
  logic [15:0] sys_drop, norm_drop;

  assign out_sys_drop_count    = sys_drop;
  assign out_normal_drop_count = norm_drop;

  // Saturating drop counters; survive flush, cleared only by reset.
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      sys_drop  <= '0;
      norm_drop <= '0;
    end else begin
      if (in_sys_flit_valid && !out_sys_ready &&
          sys_drop != 16'hFFFF)
        sys_drop <= sys_drop + 16'd1;
      if (in_normal_flit_valid && !out_normal_ready &&
          norm_drop != 16'hFFFF)
        norm_drop <= norm_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage30_out_queue.sv
// tb_stage30_out_queue: directed and random checks of the output queue
// against a queue-based reference model.
module tb_stage30_out_queue;

  localparam int SD = 4;
  localparam int ND = 8;
  localparam int SB = 2;

  logic       nocclk = 1'b0;
  logic       rst;
  logic       sv, nv, rdy, fl;
  logic [7:0] sf, nf;
  logic       sr, nr, ov;
  logic [7:0] of;
  logic [2:0] sc;
  logic [3:0] nc;
`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
  logic [15:0] sdc, ndc;
`endif

  stage30_out_queue dut (
    .nocclk               (nocclk),
    .rst                  (rst),
    .in_sys_flit_valid    (sv),
    .in_sys_flit          (sf),
    .out_sys_ready        (sr),
    .in_normal_flit_valid (nv),
    .in_normal_flit       (nf),
    .out_normal_ready     (nr),
    .out_flit_valid       (ov),
    .out_flit             (of),
    .in_flit_ready        (rdy),
    .in_flush             (fl),
`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
    .out_sys_drop_count   (sdc),
    .out_normal_drop_count(ndc),
`endif
    .out_sys_count        (sc),
    .out_normal_count     (nc)
  );

  always #5 nocclk = ~nocclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq_s[$];
  logic [7:0] mq_n[$];
  logic [7:0] obs[$];
  int m_gnt   = 0;
  int m_burst = 0;
  int m_sd    = 0;
  int m_nd    = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq_s.delete();
    mq_n.delete();
    m_gnt   = 0;
    m_burst = 0;
    m_sd    = 0;
    m_nd    = 0;
  endtask

  // Reference: one clock edge applied to the current inputs.
  task automatic model_step();
    bit valid, pop, s_rdy, n_rdy, n_pre, s_pop, n_pop;
    valid = (m_gnt != 0);
    pop   = valid && rdy;
    s_rdy = (mq_s.size() != SD);
    n_rdy = (mq_n.size() != ND);
    n_pre = (mq_n.size() != 0);
    s_pop = 0;
    n_pop = 0;
    if (sv && !s_rdy && m_sd < 65535) m_sd++;
    if (nv && !n_rdy && m_nd < 65535) m_nd++;
    if (fl) begin
      mq_s.delete();
      mq_n.delete();
      m_burst = 0;
      m_gnt   = 0;
      return;
    end
    if (pop && m_gnt == 1) begin
      void'(mq_s.pop_front());
      s_pop = 1;
    end
    if (pop && m_gnt == 2) begin
      void'(mq_n.pop_front());
      n_pop = 1;
    end
    if (sv && s_rdy) mq_s.push_back(sf);
    if (nv && n_rdy) mq_n.push_back(nf);
    if (n_pop || !n_pre) m_burst = 0;
    else if (s_pop && m_burst < SB) m_burst++;
    if (valid && !rdy) return;
    if (mq_s.size() != 0 && (m_burst < SB || mq_n.size() == 0))
      m_gnt = 1;
    else if (mq_n.size() != 0)
      m_gnt = 2;
    else
      m_gnt = 0;
  endtask

  task automatic check_all();
    logic [7:0] ef;
    ef = 8'h00;
    if (m_gnt == 1 && mq_s.size() != 0) ef = mq_s[0];
    if (m_gnt == 2 && mq_n.size() != 0) ef = mq_n[0];
    chk("valid", 32'(ov), 32'(m_gnt != 0));
    chk("flit", 32'(of), 32'(ef));
    chk("sys_ready", 32'(sr), 32'(mq_s.size() != SD));
    chk("norm_ready", 32'(nr), 32'(mq_n.size() != ND));
    chk("sys_count", 32'(sc), 32'(mq_s.size()));
    chk("norm_count", 32'(nc), 32'(mq_n.size()));
`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
    chk("sys_drops", 32'(sdc), 32'(m_sd));
    chk("norm_drops", 32'(ndc), 32'(m_nd));
`endif
  endtask

  // Drive one cycle of inputs, clock once, then compare at the negedge.
  task automatic step(bit s, logic [7:0] sd, bit n, logic [7:0] nd,
                      bit r, bit f);
    sv  = s;
    sf  = sd;
    nv  = n;
    nf  = nd;
    rdy = r;
    fl  = f;
    if (ov && r && !f) obs.push_back(of);
    @(posedge nocclk);
    model_step();
    @(negedge nocclk);
    check_all();
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, r, 0);
  endtask

  logic [7:0] exp_ord [6] = '{8'h51, 8'h52, 8'hB1, 8'h53, 8'h54, 8'hB2};

  initial begin
    rst = 1'b1;
    sv  = 0;
    nv  = 0;
    sf  = 0;
    nf  = 0;
    rdy = 0;
    fl  = 0;
    model_reset();
    repeat (2) @(negedge nocclk);
    rst = 1'b0;
    @(negedge nocclk);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_flit", 32'(of), 0);
    chk("rst_sys_ready", 32'(sr), 1);
    chk("rst_norm_ready", 32'(nr), 1);
    chk("rst_sys_count", 32'(sc), 0);
    chk("rst_norm_count", 32'(nc), 0);

    // single normal flit: visible exactly one cycle
    step(0, 8'h00, 1, 8'hA1, 1, 0);
    chk("a1_valid", 32'(ov), 1);
    chk("a1_flit", 32'(of), 32'h A1);
    idle(1, 1);
    chk("a1_gone", 32'(ov), 0);
    chk("a1_count", 32'(nc), 0);

    // bounded system priority ordering
    step(1, 8'h51, 1, 8'hB1, 0, 0);
    step(1, 8'h52, 1, 8'hB2, 0, 0);
    step(1, 8'h53, 0, 8'h00, 0, 0);
    step(1, 8'h54, 0, 8'h00, 0, 0);
    obs.delete();
    idle(7, 1);
    chk("order_len", 32'(obs.size()), 6);
    for (int i = 0; i < 6; i++)
      chk("order", 32'(i < obs.size() ? obs[i] : 8'h00), 32'(exp_ord[i]));

    // backpressure holds the system head stable
    step(1, 8'h61, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 8'(8'h70 + i), 0, 0);
      chk("stall_valid", 32'(ov), 1);
      chk("stall_flit", 32'(of), 32'h61);
    end
    obs.delete();
    idle(1, 1);
    chk("stall_accept", 32'(obs.size() != 0 ? obs[0] : 8'h00), 32'h61);
    idle(8, 1);

    // overflow of the normal FIFO
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 8'(8'hC0 + i), 0, 0);
    step(0, 8'h00, 1, 8'hC9, 0, 0);
    chk("full_count", 32'(nc), 8);
    chk("full_ready", 32'(nr), 0);
    chk("full_head", 32'(of), 32'hC0);
`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
    chk("full_drop", 32'(ndc), 1);
`endif
    idle(10, 1);

    // flush with pending entries and simultaneous pushes
    for (int i = 0; i < 3; i++)
      step(1, 8'(8'hD0 + i), 1, 8'(8'hE0 + i), 0, 0);
    step(1, 8'hDF, 1, 8'hEF, 1, 1);
    chk("flush_sys_count", 32'(sc), 0);
    chk("flush_norm_count", 32'(nc), 0);
    chk("flush_valid", 32'(ov), 0);
`ifdef STAGE30_OUT_QUEUE_DROP_STATS_EN
    chk("flush_drop", 32'(ndc), 1);
`endif

    // asynchronous reset mid-transfer
    step(1, 8'h31, 1, 8'h41, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov), 0);
    chk("arst_sys_count", 32'(sc), 0);
    chk("arst_norm_count", 32'(nc), 0);
    model_reset();
    @(negedge nocclk);
    rst = 1'b0;
    idle(1, 1);

    // randomized traffic, alternating light and heavy backpressure
    for (int i = 0; i < 4000; i++) begin
      bit ph;
      ph = ((i / 400) % 2) == 1;
      step($urandom_range(0, 2) == 0, 8'($urandom),
           $urandom_range(0, 1) == 0, 8'($urandom),
           ph ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 99) == 0);
    end
    idle(16, 1);
    chk("drain_valid", 32'(ov), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
